bus_slave_regfile: RTL and testbench



---
 rtl/bus_slave_regfile_if.sv | 15 +
 rtl/bus_slave_regfile.sv | 174 +++++++++++++++++
 tb/tb_bus_slave_regfile.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_regfile_if.sv
// Timer-bus req/gnt signal bundle shared by the verification master and the register-file slave.
interface bus_slave_regfile_if #(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 32
) ();
  logic                    req;
  logic [P_ADDR_WIDTH-1:0] addr;
  logic [P_DATA_WIDTH-1:0] wdata;
  logic                    write_en;
  logic                    gnt;
  logic [P_DATA_WIDTH-1:0] rdata;

  modport master (output req, addr, wdata, write_en, input gnt, rdata);
  modport slave  (input req, addr, wdata, write_en, output gnt, rdata);
endinterface

// File: rtl/bus_slave_regfile.sv
// Timer-bus slave: word-addressed register file with programmable wait states, one-cycle
// grant per transfer, per-register write strobes and a sticky protocol/decode error flag.
module bus_slave_regfile #(
  parameter int                    P_ADDR_WIDTH = 8,
  parameter int                    P_DATA_WIDTH = 32,
  parameter int                    NUM_REGS     = 16,
  parameter int                    WAIT_STATES  = 1,
  parameter logic [P_DATA_WIDTH-1:0] ID_VALUE   = 32'h5449_4D31
) (
  input  logic                             clk,
  input  logic                             reset,
  bus_slave_regfile_if.slave               bus,
  output logic [NUM_REGS*P_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]              wr_strobe_o,
  output logic                             err_o
);

  localparam int                    LP_IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [P_ADDR_WIDTH:0] LP_NUM_REGS = NUM_REGS[P_ADDR_WIDTH:0];
  localparam logic [3:0]            LP_WAIT     = WAIT_STATES[3:0];

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    gnt_q, gnt_d;
  logic [P_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0]     strobe_q, strobe_d;
  logic                    err_q, err_d;
  logic [P_DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];

  logic                    in_range_s;
  logic [LP_IDX_W-1:0]     idx_s;
  logic [P_DATA_WIDTH-1:0] rd_val_s;

  // Decode the latched address and select read data (register 0 is the ID word).
  always_comb begin
    in_range_s = ({1'b0, addr_q} < LP_NUM_REGS);
    idx_s      = addr_q[LP_IDX_W-1:0];
    rd_val_s   = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      rd_val_s = rd_val_s | ((idx_s == LP_IDX_W'(i)) ? regs_q[i] : '0);
    end
    if (!in_range_s) begin
      rd_val_s = '0;
    end else if (idx_s == '0) begin
      rd_val_s = ID_VALUE;
    end else begin
      rd_val_s = rd_val_s;
    end
  end

  // Transfer FSM: next state and next values of all registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    gnt_d    = 1'b0;
    strobe_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          we_d    = bus.write_en;
          cnt_d   = LP_WAIT;
          state_d = (LP_WAIT == 4'd0) ? ST_GRANT : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A master that drops req before grant has broken the protocol.
        if (!bus.req) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_GRANT;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_GRANT: begin
        gnt_d   = 1'b1;
        state_d = ST_RECOVER;
        if (!in_range_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (we_q) begin
          if (in_range_s && (idx_s != '0)) begin
            strobe_d[idx_s] = 1'b1;
          end else begin
            strobe_d = '0;
          end
        end else begin
          rdata_d = rd_val_s;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, latched request fields and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      gnt_q    <= 1'b0;
      rdata_q  <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  // Register file commits on the strobe, so new data shows on regs_o the cycle after gnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (strobe_q[i]) begin
          regs_q[i] <= wdata_q;
        end
      end
    end
  end

  assign regs_o[0 +: P_DATA_WIDTH] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*P_DATA_WIDTH +: P_DATA_WIDTH] = regs_q[g];
  end

  assign wr_strobe_o = strobe_q;
  assign err_o       = err_q;
  assign bus.gnt     = gnt_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_bus_slave_regfile.sv
// Bench for bus_slave_regfile: directed vector table, multi-cycle corner sequences and
// random transfers scored against an array-based register-file model.
module tb_bus_slave_regfile;
  localparam logic [31:0] ID = 32'h5449_4D31;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [15:0] exp_stb;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_slave_regfile_if #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32)) bus ();
  bus_slave_regfile_if #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32)) bus3 ();
  logic [511:0] regs, regs3;
  logic [15:0]  strb, strb3;
  logic         err, err3;

  bus_slave_regfile #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32), .NUM_REGS(16),
                      .WAIT_STATES(1), .ID_VALUE(ID)) dut (
    .clk(clk), .reset(reset), .bus(bus), .regs_o(regs), .wr_strobe_o(strb), .err_o(err));

  bus_slave_regfile #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32), .NUM_REGS(16),
                      .WAIT_STATES(3), .ID_VALUE(ID)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .regs_o(regs3), .wr_strobe_o(strb3), .err_o(err3));

  int total = 0;
  int bad = 0;
  int gnt_cnt = 0;
  int stb_cnt = 0;

  logic [31:0] m_regs [16];
  logic        m_err;
  logic [31:0] m_rdata;

  always @(negedge clk) begin
    if (bus.gnt) gnt_cnt++;
    stb_cnt += $countones(strb);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] slice(input logic [511:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  function automatic logic [31:0] m_view(input int i);
    return (i == 0) ? ID : m_regs[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_err   = 1'b0;
    m_rdata = 32'h0;
  endtask

  // Register-file rules: reg 0 reads ID and ignores writes, >=16 is an error, reads 0, drops writes.
  task automatic model_xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] e_rd, output logic [15:0] e_stb, output logic e_er);
    e_stb = 16'h0000;
    if (a >= 8'd16) m_err = 1'b1;
    if (!we) begin
      m_rdata = (a >= 8'd16) ? 32'h0 : ((a == 8'd0) ? ID : m_regs[a[3:0]]);
    end else if ((a < 8'd16) && (a != 8'd0)) begin
      m_regs[a[3:0]] = d;
      e_stb = 16'h0001 << a[3:0];
    end
    e_rd = m_rdata;
    e_er = m_err;
  endtask

  task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic [15:0] stb, output logic er);
    bus.req = 1'b1; bus.write_en = we; bus.addr = a; bus.wdata = d;
    lat = -1; rd = 32'h0; stb = 16'h0; er = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.gnt) begin
        lat = c; rd = bus.rdata; stb = strb; er = err;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.req = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t        vecs [9];
    int          lat, seen, g0, s0;
    logic [31:0] rd, e_rd, d;
    logic [15:0] stb, e_stb;
    logic        er, e_er, we;
    logic [7:0]  a;

    bus.req = 1'b0;  bus.addr = 8'h0;  bus.wdata = 32'h0;  bus.write_en = 1'b0;
    bus3.req = 1'b0; bus3.addr = 8'h0; bus3.wdata = 32'h0; bus3.write_en = 1'b0;
    model_reset();

    vecs[0] = '{1'b0, 8'h00, 32'h0000_0000, ID,            16'h0000, 1'b0};
    vecs[1] = '{1'b1, 8'h03, 32'hA5A5_0001, ID,            16'h0008, 1'b0};
    vecs[2] = '{1'b0, 8'h03, 32'h0000_0000, 32'hA5A5_0001, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 32'hDEAD_BEEF, 32'hA5A5_0001, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 32'h0000_0000, ID,            16'h0000, 1'b0};
    vecs[5] = '{1'b1, 8'h20, 32'h1234_5678, ID,            16'h0000, 1'b1};
    vecs[6] = '{1'b0, 8'h20, 32'h0000_0000, 32'h0000_0000, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 8'h0F, 32'hFFFF_0000, 32'h0000_0000, 16'h8000, 1'b1};
    vecs[8] = '{1'b0, 8'h0F, 32'h0000_0000, 32'hFFFF_0000, 16'h0000, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", bus.gnt, 1'b0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_strobe", strb, 16'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_slice0", slice(regs, 0), ID);
    chk("rst_slice5", slice(regs, 5), 32'h0);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, stb, er);
      idle(1);
      chk($sformatf("tbl%0d_lat", i), lat, 2);
      chk($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("tbl%0d_strobe", i), stb, vecs[i].exp_stb);
      chk($sformatf("tbl%0d_err", i), er, vecs[i].exp_err);
      model_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, e_rd, e_stb, e_er);
    end
    chk("tbl_slice3", slice(regs, 3), 32'hA5A5_0001);
    chk("tbl_slice0", slice(regs, 0), ID);
    chk("tbl_slice15", slice(regs, 15), 32'hFFFF_0000);

    // Back-to-back with req held high across the first grant.
    g0 = gnt_cnt; s0 = stb_cnt;
    xfer(1'b1, 8'h06, 32'h0606_1111, lat, rd, stb, er);
    chk("b2b_first_lat", lat, 2);
    chk("b2b_first_strobe", stb, 16'h0040);
    xfer(1'b1, 8'h07, 32'h0707_2222, lat, rd, stb, er);
    chk("b2b_period", lat + 1, 4);
    chk("b2b_second_strobe", stb, 16'h0080);
    idle(4);
    chk("b2b_gnt_count", gnt_cnt - g0, 2);
    chk("b2b_strobe_count", stb_cnt - s0, 2);
    chk("b2b_slice6", slice(regs, 6), 32'h0606_1111);
    chk("b2b_slice7", slice(regs, 7), 32'h0707_2222);
    model_xfer(1'b1, 8'h06, 32'h0606_1111, e_rd, e_stb, e_er);
    model_xfer(1'b1, 8'h07, 32'h0707_2222, e_rd, e_stb, e_er);

    // Three-wait-state slave: master abandons the request mid-wait.
    chk("ws3_err_before", err3, 1'b0);
    bus3.req = 1'b1; bus3.write_en = 1'b1; bus3.addr = 8'h02; bus3.wdata = 32'hCAFE_0002;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus3.req = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus3.gnt || (strb3 != 16'h0)) seen++;
    end
    chk("ws3_drop_no_gnt", seen, 0);
    chk("ws3_drop_err", err3, 1'b1);
    chk("ws3_drop_slice2", slice(regs3, 2), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("ws3_err_sticky", err3, 1'b1);
    bus3.req = 1'b1; bus3.write_en = 1'b0; bus3.addr = 8'h02;
    lat = -1; rd = 32'hFFFF_FFFF;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus3.gnt) begin
        lat = c; rd = bus3.rdata;
        break;
      end
    end
    bus3.req = 1'b0;
    chk("ws3_lat", lat, 4);
    chk("ws3_rdata", rd, 32'h0);
    chk("ws3_err_after", err3, 1'b1);

    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 19));
      d  = $urandom;
      model_xfer(we, a, d, e_rd, e_stb, e_er);
      xfer(we, a, d, lat, rd, stb, er);
      idle($urandom_range(1, 3));
      chk($sformatf("rnd%0d_lat", n), lat, 2);
      chk($sformatf("rnd%0d_rdata a=%0h", n, a), rd, e_rd);
      chk($sformatf("rnd%0d_strobe a=%0h", n, a), stb, e_stb);
      chk($sformatf("rnd%0d_err", n), er, e_er);
      if (we && (a < 8'd16)) chk($sformatf("rnd%0d_slice a=%0h", n, a), slice(regs, int'(a)), m_view(int'(a)));
    end
    for (int i = 0; i < 16; i++) chk($sformatf("final_slice%0d", i), slice(regs, i), m_view(i));

    // Reset asserted while a transfer sits in WAIT.
    xfer(1'b1, 8'h05, 32'h5555_AAAA, lat, rd, stb, er);
    idle(1);
    model_xfer(1'b1, 8'h05, 32'h5555_AAAA, e_rd, e_stb, e_er);
    chk("rst_mid_pre_slice5", slice(regs, 5), 32'h5555_AAAA);
    bus.req = 1'b1; bus.write_en = 1'b1; bus.addr = 8'h05; bus.wdata = 32'h0BAD_0BAD;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_gnt", bus.gnt, 1'b0);
    chk("rst_mid_slice5", slice(regs, 5), 32'h0);
    chk("rst_mid_err", err, 1'b0);
    chk("rst_mid_strobe", strb, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req = 1'b0;
    model_reset();
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.gnt || (strb != 16'h0)) seen++;
    end
    chk("rst_mid_no_gnt", seen, 0);
    xfer(1'b0, 8'h05, 32'h0, lat, rd, stb, er);
    idle(1);
    chk("rst_after_lat", lat, 2);
    chk("rst_after_rdata", rd, 32'h0);
    chk("rst_after_err", er, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
